// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared definitions for the I2C bus arbiter: FSM state encoding and I2C field widths.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_OWNED   = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2c_bus_arbiter_rr_picker.sv
// Combinational N-way round-robin select: first requester after 'last', with wrap-around.
module rr_picker
    import i2c_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    // Walk from farthest to nearest so the nearest requester after 'last' wins.
    always_comb begin
        idx  = '0;
        cand = '0;
        any  = |req;
        for (int i = N; i >= 1; i--) begin
            cand = IW'((int'(last) + i) % N);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin owner arbitration of one i2c_master among N clients with an ownership watchdog.
// Grant is registered (1 cycle after request); command/response mux is combinational.
module i2c_bus_arbiter
    import i2c_pkg::*;
#(
    parameter int N_CLIENTS      = 2,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                              clk,
    input  logic                              rst,

    input  logic [N_CLIENTS-1:0]              i_req,
    output logic [N_CLIENTS-1:0]              o_gnt,
    output logic [N_CLIENTS-1:0]              o_timeout,

    input  logic [I2C_ADDR_W*N_CLIENTS-1:0]   i_c_addr,
    input  logic [I2C_DATA_W*N_CLIENTS-1:0]   i_c_wdata,
    input  logic [N_CLIENTS-1:0]              i_c_rw,
    input  logic [N_CLIENTS-1:0]              i_c_start,
    input  logic [N_CLIENTS-1:0]              i_c_stop,
    input  logic [N_CLIENTS-1:0]              i_c_wvalid,
    input  logic [N_CLIENTS-1:0]              i_c_rready,
    input  logic [N_CLIENTS-1:0]              i_c_ack_send,

    output logic [I2C_DATA_W-1:0]             o_c_rdata,
    output logic                              o_c_ack_recv,
    output logic [N_CLIENTS-1:0]              o_c_rvalid,
    output logic [N_CLIENTS-1:0]              o_c_wready,
    output logic [N_CLIENTS-1:0]              o_c_done,
    output logic [N_CLIENTS-1:0]              o_c_busy,

    output logic [I2C_ADDR_W-1:0]             o_m_addr,
    output logic [I2C_DATA_W-1:0]             o_m_wdata,
    output logic                              o_m_rw,
    output logic                              o_m_start,
    output logic                              o_m_stop,
    output logic                              o_m_wvalid,
    output logic                              o_m_rready,
    output logic                              o_m_ack_send,

    input  logic [I2C_DATA_W-1:0]             i_m_rdata,
    input  logic                              i_m_rvalid,
    input  logic                              i_m_wready,
    input  logic                              i_m_ack_recv,
    input  logic                              i_m_busy,
    input  logic                              i_m_done
);

    localparam int IW = idx_w(N_CLIENTS);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] WD_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_CLIENTS - 1);

    arb_state_t    state;
    logic [IW-1:0] owner;
    logic [IW-1:0] last;
    logic [CW-1:0] wd_cnt;
    logic [IW-1:0] pick_idx;
    logic          pick_any;

    rr_picker #(
        .N  (N_CLIENTS),
        .IW (IW)
    ) u_rr_picker (
        .req  (i_req),
        .last (last),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            owner     <= '0;
            last      <= LAST_IDX;
            wd_cnt    <= '0;
            o_gnt     <= '0;
            o_timeout <= '0;
        end else begin
            o_timeout <= '0;
            case (state)
                ARB_IDLE: begin
                    if (pick_any && !i_m_busy) begin
                        owner  <= pick_idx;
                        o_gnt  <= N_CLIENTS'(1) << pick_idx;
                        wd_cnt <= '0;
                        state  <= ARB_OWNED;
                    end
                end
                ARB_OWNED: begin
                    // A clean release wins over a watchdog expiry in the same cycle.
                    if (!i_req[owner]) begin
                        o_gnt <= '0;
                        last  <= owner;
                        state <= ARB_RELEASE;
                    end else if (wd_cnt == WD_LAST) begin
                        o_gnt            <= '0;
                        o_timeout[owner] <= 1'b1;
                        last             <= owner;
                        state            <= ARB_RELEASE;
                    end else if (wd_cnt != '1) begin
                        wd_cnt <= wd_cnt + CW'(1);
                    end
                end
                ARB_RELEASE: begin
                    if (!i_m_busy) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign o_c_rdata    = i_m_rdata;
    assign o_c_ack_recv = i_m_ack_recv;

    // Outside OWNED nobody drives the master; in RELEASE a pending transfer is asked to STOP.
    always_comb begin
        o_m_addr     = '0;
        o_m_wdata    = '0;
        o_m_rw       = 1'b0;
        o_m_start    = 1'b0;
        o_m_stop     = 1'b0;
        o_m_wvalid   = 1'b0;
        o_m_rready   = 1'b0;
        o_m_ack_send = 1'b0;
        o_c_rvalid   = '0;
        o_c_wready   = '0;
        o_c_done     = '0;
        o_c_busy     = '1;
        case (state)
            ARB_OWNED: begin
                o_m_addr          = i_c_addr[int'(owner)*I2C_ADDR_W +: I2C_ADDR_W];
                o_m_wdata         = i_c_wdata[int'(owner)*I2C_DATA_W +: I2C_DATA_W];
                o_m_rw            = i_c_rw[owner];
                o_m_start         = i_c_start[owner];
                o_m_stop          = i_c_stop[owner];
                o_m_wvalid        = i_c_wvalid[owner];
                o_m_rready        = i_c_rready[owner];
                o_m_ack_send      = i_c_ack_send[owner];
                o_c_rvalid[owner] = i_m_rvalid;
                o_c_wready[owner] = i_m_wready;
                o_c_done[owner]   = i_m_done;
                o_c_busy[owner]   = i_m_busy;
            end
            ARB_RELEASE: begin
                o_m_stop = i_m_busy;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Randomized bench for i2c_bus_arbiter: a scripted timeline model predicts grant/release events and per-cycle routing.
module tb_i2c_bus_arbiter;

    localparam int NC = 2;
    localparam int TO = 100;
    localparam int AW = NC * 7;
    localparam int DW = NC * 8;
    localparam int M_IDLE = 0;
    localparam int M_OWN  = 1;
    localparam int M_REL  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NC-1:0] req = '0;
    logic [NC-1:0] gnt, tmo;
    logic [AW-1:0] c_addr = '0;
    logic [DW-1:0] c_wdata = '0;
    logic [NC-1:0] c_rw = '0, c_start = '0, c_stop = '0, c_wvalid = '0, c_rready = '0, c_ack_send = '0;
    logic [7:0]    c_rdata;
    logic          c_ack_recv;
    logic [NC-1:0] c_rvalid, c_wready, c_done, c_busy;
    logic [6:0]    m_addr;
    logic [7:0]    m_wdata;
    logic          m_rw, m_start, m_stop, m_wvalid, m_rready, m_ack_send;
    logic [7:0]    m_rdata = '0;
    logic          m_rvalid = 1'b0, m_wready = 1'b0, m_ack_recv = 1'b0, m_busy = 1'b0, m_done = 1'b0;

    always #5 clk = ~clk;

    i2c_bus_arbiter #(
        .N_CLIENTS      (NC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req        (req),
        .o_gnt        (gnt),
        .o_timeout    (tmo),
        .i_c_addr     (c_addr),
        .i_c_wdata    (c_wdata),
        .i_c_rw       (c_rw),
        .i_c_start    (c_start),
        .i_c_stop     (c_stop),
        .i_c_wvalid   (c_wvalid),
        .i_c_rready   (c_rready),
        .i_c_ack_send (c_ack_send),
        .o_c_rdata    (c_rdata),
        .o_c_ack_recv (c_ack_recv),
        .o_c_rvalid   (c_rvalid),
        .o_c_wready   (c_wready),
        .o_c_done     (c_done),
        .o_c_busy     (c_busy),
        .o_m_addr     (m_addr),
        .o_m_wdata    (m_wdata),
        .o_m_rw       (m_rw),
        .o_m_start    (m_start),
        .o_m_stop     (m_stop),
        .o_m_wvalid   (m_wvalid),
        .o_m_rready   (m_rready),
        .o_m_ack_send (m_ack_send),
        .i_m_rdata    (m_rdata),
        .i_m_rvalid   (m_rvalid),
        .i_m_wready   (m_wready),
        .i_m_ack_recv (m_ack_recv),
        .i_m_busy     (m_busy),
        .i_m_done     (m_done)
    );

    typedef struct {
        bit rel;
        int client;
        int cyc;
        bit to;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    int  exp_mode = M_IDLE;
    int  exp_owner = 0;
    bit  exp_to = 1'b0;
    bit  chk_en = 1'b0;
    int  m_last = NC - 1;
    logic [NC-1:0] prev_gnt = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NC-1:0] m, input int last);
        for (int i = 1; i <= NC; i++) begin
            if (m[(last + i) % NC]) return (last + i) % NC;
        end
        return -1;
    endfunction

    function automatic int oh_idx(input logic [NC-1:0] v);
        int idx = 255;
        int n = 0;
        for (int i = 0; i < NC; i++) begin
            if (v[i]) begin
                idx = i;
                n++;
            end
        end
        return (n == 1) ? idx : 255;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic [NC-1:0] e_gnt, e_to, e_rv, e_wr, e_dn, e_bz;
    logic [20:0]   e_m;
    bit            a_rel, a_to;
    int            a_cl;
    ev_t           ev;

    always @(negedge clk) begin
        if (chk_en) begin
            e_gnt = '0; e_to = '0; e_m = '0;
            e_rv = '0; e_wr = '0; e_dn = '0; e_bz = '1;
            if (exp_mode == M_OWN) begin
                e_gnt[exp_owner] = 1'b1;
                e_m = {c_addr[exp_owner*7 +: 7], c_wdata[exp_owner*8 +: 8], c_rw[exp_owner],
                       c_start[exp_owner], c_stop[exp_owner], c_wvalid[exp_owner],
                       c_rready[exp_owner], c_ack_send[exp_owner]};
                e_rv[exp_owner] = m_rvalid;
                e_wr[exp_owner] = m_wready;
                e_dn[exp_owner] = m_done;
                e_bz[exp_owner] = m_busy;
            end else if (exp_mode == M_REL) begin
                e_m[3] = m_busy;
                if (exp_to) e_to[exp_owner] = 1'b1;
            end
            chk("gnt", 64'(gnt), 64'(e_gnt));
            chk("timeout", 64'(tmo), 64'(e_to));
            chk("master_cmd", 64'({m_addr, m_wdata, m_rw, m_start, m_stop, m_wvalid, m_rready, m_ack_send}), 64'(e_m));
            chk("client_rsp", 64'({c_rvalid, c_wready, c_done, c_busy}), 64'({e_rv, e_wr, e_dn, e_bz}));
            chk("broadcast", 64'({c_rdata, c_ack_recv}), 64'({m_rdata, m_ack_recv}));

            if (gnt !== prev_gnt) begin
                checks++;
                a_rel = (gnt == '0);
                a_cl  = oh_idx(a_rel ? prev_gnt : gnt);
                a_to  = |tmo;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL gnt_event cyc=%0d actual gnt=%b required no grant change", cyc, gnt);
                end else begin
                    ev = exp_q.pop_front();
                    if (a_rel != ev.rel || a_cl != ev.client || cyc != ev.cyc || a_to != ev.to) begin
                        errors++;
                        $display("FAIL gnt_event actual rel=%0d client=%0d cyc=%0d timeout=%0d required rel=%0d client=%0d cyc=%0d timeout=%0d",
                                 a_rel, a_cl, cyc, a_to, ev.rel, ev.client, ev.cyc, ev.to);
                    end
                end
            end
            prev_gnt = gnt;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        c_addr     = AW'($urandom);
        c_wdata    = DW'($urandom);
        c_rw       = NC'($urandom);
        c_start    = NC'($urandom);
        c_stop     = NC'($urandom);
        c_wvalid   = NC'($urandom);
        c_rready   = NC'($urandom);
        c_ack_send = NC'($urandom);
        m_rdata    = 8'($urandom);
        m_rvalid   = 1'($urandom);
        m_wready   = 1'($urandom);
        m_ack_recv = 1'($urandom);
        m_done     = 1'($urandom);
    endtask

    task automatic set_exp(input int mode, input int owner, input bit to);
        exp_mode  = mode;
        exp_owner = owner;
        exp_to    = to;
    endtask

    // Requesters in 'mask' rise together and are each served once, in round-robin order.
    task automatic run_round(input logic [NC-1:0] mask, input bit want_to, input bit do_rst);
        logic [NC-1:0] pending;
        int g, r, d, p, b, w;
        bit to, first;
        tick();
        set_exp(M_IDLE, 0, 1'b0);
        m_busy  = 1'b0;
        req     = mask;
        pending = mask;
        g       = cyc + 1;
        first   = 1'b1;
        while (pending != '0) begin
            w  = rr_pick(pending, m_last);
            to = want_to && first;
            r  = to ? g + TO : g + 1 + int'($urandom_range(0, 12));
            b  = int'($urandom_range(0, 3));
            d  = r - 1;
            p  = (b > 1) ? r + b : r + 1;
            exp_q.push_back('{1'b0, w, g, 1'b0});
            exp_q.push_back('{1'b1, w, r, to});
            while (cyc < d) begin
                tick();
                set_exp(M_OWN, w, 1'b0);
                m_busy = 1'($urandom);
            end
            if (do_rst && first) begin
                rst = 1'b1;
                tick();
                set_exp(M_IDLE, 0, 1'b0);
                rst    = 1'b0;
                req    = '0;
                m_busy = 1'b0;
                m_last = NC - 1;
                return;
            end
            m_busy = (b > 0);
            if (!to) req[w] = 1'b0;
            while (cyc < p - 1) begin
                tick();
                set_exp(M_REL, w, to && (cyc == r));
                m_busy = (cyc < d + b);
                if (cyc == r) req[w] = 1'b0;
            end
            tick();
            set_exp(M_IDLE, 0, 1'b0);
            m_busy     = 1'b0;
            pending[w] = 1'b0;
            m_last     = w;
            g          = cyc + 1;
            first      = 1'b0;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        run_round(2'b01, 1'b0, 1'b0);
        run_round(2'b11, 1'b0, 1'b0);
        run_round(2'b11, 1'b1, 1'b0);
        run_round(2'b01, 1'b1, 1'b0);
        for (int i = 0; i < 25; i++) begin
            run_round(NC'($urandom_range(1, (1 << NC) - 1)), ($urandom_range(0, 7) == 0), 1'b0);
        end
        run_round(2'b11, 1'b0, 1'b1);
        run_round(2'b11, 1'b0, 1'b0);
        repeat (4) tick();
        chk("events_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
